// File: rtl/csum_adder_pipe.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready handshake on both sides.
// Leaf sum-pairs are merged over log2(WIDTH) levels; the effective carry-in then selects the result.
module csum_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LVLS = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("csum_adder_pipe: WIDTH must be a power of two, at least 2");
  end

  // The whole pipeline moves in lockstep: one global advance, no bubble collapsing.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic             in_v;
  logic             c_r;
  logic             am_r;
  logic             bm_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;

  // NOTE: state uses non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v <= 1'b0;
      c_r  <= 1'b0;
      am_r <= 1'b0;
      bm_r <= 1'b0;
      a_r  <= '0;
      bx_r <= '0;
    end else if (advance) begin
      in_v <= in_valid;
      a_r  <= a;
      bx_r <= sub ? ~b : b;
      c_r  <= sub | cin;
      am_r <= a[WIDTH-1];
      bm_r <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end
  end

  // Level k holds, for each 2^k-bit group, the result assuming group carry-in 0 (s0/c0) and 1 (s1/c1).
  for (genvar k = 0; k <= LVLS; k++) begin : lvl
    localparam int G = WIDTH >> k;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [G-1:0]     c0;
    logic [G-1:0]     c1;
    logic             v;
    logic             c;
    logic             am;
    logic             bm;

    if (k == 0) begin : g_leaf
      assign s0 = a_r ^ bx_r;
      assign s1 = ~(a_r ^ bx_r);
      assign c0 = a_r & bx_r;
      assign c1 = a_r | bx_r;
      assign v  = in_v;
      assign c  = c_r;
      assign am = am_r;
      assign bm = bm_r;
    end else begin : g_merge
      localparam int H = 1 << (k - 1);
      logic [WIDTH-1:0] p_s0;
      logic [WIDTH-1:0] p_s1;
      logic [2*G-1:0]   p_c0;
      logic [2*G-1:0]   p_c1;
      logic [WIDTH-1:0] m_s0;
      logic [WIDTH-1:0] m_s1;
      logic [G-1:0]     m_c0;
      logic [G-1:0]     m_c1;

      assign p_s0 = lvl[k-1].s0;
      assign p_s1 = lvl[k-1].s1;
      assign p_c0 = lvl[k-1].c0;
      assign p_c1 = lvl[k-1].c1;

      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      always_comb begin
        m_s0 = p_s0;
        m_s1 = p_s1;
        m_c0 = '0;
        m_c1 = '0;
        for (int g = 0; g < G; g++) begin
          m_s0[(2*g+1)*H +: H] = p_c0[2*g] ? p_s1[(2*g+1)*H +: H] : p_s0[(2*g+1)*H +: H];
          m_c0[g]              = p_c0[2*g] ? p_c1[2*g+1]          : p_c0[2*g+1];
          m_s1[(2*g+1)*H +: H] = p_c1[2*g] ? p_s1[(2*g+1)*H +: H] : p_s0[(2*g+1)*H +: H];
          m_c1[g]              = p_c1[2*g] ? p_c1[2*g+1]          : p_c0[2*g+1];
        end
      end

      if (PIPE != 0) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v  <= 1'b0;
            c  <= 1'b0;
            am <= 1'b0;
            bm <= 1'b0;
            s0 <= '0;
            s1 <= '0;
            c0 <= '0;
            c1 <= '0;
          end else if (advance) begin
            v  <= lvl[k-1].v;
            c  <= lvl[k-1].c;
            am <= lvl[k-1].am;
            bm <= lvl[k-1].bm;
            s0 <= m_s0;
            s1 <= m_s1;
            c0 <= m_c0;
            c1 <= m_c1;
          end
        end
      end else begin : g_comb
        assign v  = lvl[k-1].v;
        assign c  = lvl[k-1].c;
        assign am = lvl[k-1].am;
        assign bm = lvl[k-1].bm;
        assign s0 = m_s0;
        assign s1 = m_s1;
        assign c0 = m_c0;
        assign c1 = m_c1;
      end
    end
  end

  logic [WIDTH-1:0] sel_sum;
  logic             sel_cout;
  logic             sel_ovf;
  assign sel_sum  = lvl[LVLS].c ? lvl[LVLS].s1    : lvl[LVLS].s0;
  assign sel_cout = lvl[LVLS].c ? lvl[LVLS].c1[0] : lvl[LVLS].c0[0];
  assign sel_ovf  = (lvl[LVLS].am == lvl[LVLS].bm) && (sel_sum[WIDTH-1] != lvl[LVLS].am);

  // Output data only loads on a valid beat so bubbles leave the last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= lvl[LVLS].v;
      if (lvl[LVLS].v) begin
        sum  <= sel_sum;
        cout <= sel_cout;
        ovf  <= sel_ovf;
      end
    end
  end
endmodule

// File: tb/tb_csum_adder_pipe.sv
// Scoreboard bench for csum_adder_pipe: 16-bit pipelined, 8-bit combinational and 64-bit pipelined instances.
module tb_csum_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv64, ir64, ci64, sb64, ov64, or64, co64, of64;
  logic [63:0] a64, b64, s64;

  csum_adder_pipe #(.WIDTH(16), .PIPE(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16));
  csum_adder_pipe #(.WIDTH(8), .PIPE(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8), .sub(sb8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  csum_adder_pipe #(.WIDTH(64), .PIPE(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .cin(ci64), .sub(sb64),
    .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(co64), .ovf(of64));

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t q64[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   popped[3];

  logic        obs_valid, obs_ready, obs_cout, obs_ovf;
  logic [63:0] obs_sum;

  function automatic int width_of(input int which);
    return (which == 0) ? 16 : (which == 1) ? 8 : 64;
  endfunction

  function automatic string dname(input int which);
    return (which == 0) ? "w16" : (which == 1) ? "w8" : "w64";
  endfunction

  // Reference: plain wide addition of the effective operands.
  function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tbv,
                                 input logic tcin, input logic tsub);
    logic [63:0] mask, am, bx;
    logic [64:0] full;
    exp_t        r;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am     = ta & mask;
    bx     = (tsub ? ~tbv : tbv) & mask;
    full   = {1'b0, am} + {1'b0, bx} + {64'd0, (tsub | tcin)};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bx[w-1]) && (r.sum[w-1] != am[w-1]);
    return r;
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? q16.size() : (which == 1) ? q8.size() : q64.size();
  endfunction

  task automatic push_exp(input int which, input exp_t e);
    case (which)
      0:       q16.push_back(e);
      1:       q8.push_back(e);
      default: q64.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int which, output exp_t e);
    case (which)
      0:       e = q16.pop_front();
      1:       e = q8.pop_front();
      default: e = q64.pop_front();
    endcase
  endtask

  task automatic drive(input int which, input logic v, input logic [63:0] ta, input logic [63:0] tbv,
                       input logic tcin, input logic tsub, input logic ordy);
    case (which)
      0: begin iv16 = v; a16 = ta[15:0]; b16 = tbv[15:0]; ci16 = tcin; sb16 = tsub; or16 = ordy; end
      1: begin iv8  = v; a8  = ta[7:0];  b8  = tbv[7:0];  ci8  = tcin; sb8  = tsub; or8  = ordy; end
      default: begin iv64 = v; a64 = ta; b64 = tbv; ci64 = tcin; sb64 = tsub; or64 = ordy; end
    endcase
  endtask

  task automatic sample(input int which);
    case (which)
      0: begin obs_valid = ov16; obs_ready = ir16; obs_sum = {48'd0, s16}; obs_cout = co16; obs_ovf = of16; end
      1: begin obs_valid = ov8;  obs_ready = ir8;  obs_sum = {56'd0, s8};  obs_cout = co8;  obs_ovf = of8;  end
      default: begin obs_valid = ov64; obs_ready = ir64; obs_sum = s64; obs_cout = co64; obs_ovf = of64; end
    endcase
  endtask

  // One clock of traffic: drive at negedge, push on acceptance, pop and compare on output transfer.
  task automatic cycle(input int which, input logic v, input logic [63:0] ta, input logic [63:0] tbv,
                       input logic tcin, input logic tsub, input logic ordy, output logic acc);
    exp_t e, got;
    @(negedge clk);
    drive(which, v, ta, tbv, tcin, tsub, ordy);
    #1;
    sample(which);
    acc = v && obs_ready;
    if (acc) push_exp(which, model(width_of(which), ta, tbv, tcin, tsub));
    if (obs_valid && ordy) begin
      popped[which]++;
      tests_run++;
      got = {obs_sum, obs_cout, obs_ovf};
      if (qsize(which) == 0) begin
        tests_failed++;
        $display("FAIL %s unexpected_result: got sum=%h with nothing expected", dname(which), obs_sum);
      end else begin
        pop_exp(which, e);
        if (got !== e) begin
          tests_failed++;
          $display("FAIL %s result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   dname(which), got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  endtask

  task automatic drain(input int which);
    logic acc;
    int   n = 0;
    while (qsize(which) > 0 && n < 50) begin
      cycle(which, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    tests_run++;
    if (qsize(which) != 0) begin
      tests_failed++;
      $display("FAIL %s drain: %0d results still outstanding, expected 0", dname(which), qsize(which));
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 3; w++) begin
      sample(w);
      tests_run++;
      if (obs_valid !== 1'b0 || obs_sum !== 64'd0 || obs_cout !== 1'b0 || obs_ovf !== 1'b0 || obs_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s reset_state: got valid=%b sum=%h cout=%b ovf=%b ready=%b, expected 0/0/0/0/1",
                 dname(w), obs_valid, obs_sum, obs_cout, obs_ovf, obs_ready);
      end
    end
  endtask

  task automatic test_latency(input int which, input int exp_lat, input logic [63:0] ta, input logic [63:0] tbv);
    logic acc;
    int   lat  = 0;
    bit   seen = 1'b0;
    cycle(which, 1'b1, ta, tbv, 1'b0, 1'b0, 1'b1, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s latency_accept: got accepted=%b, expected 1", dname(which), acc);
    end
    while (!seen && lat < 40) begin
      cycle(which, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
      seen = obs_valid;
    end
    tests_run++;
    if (!seen || lat != exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles (seen=%0b), expected %0d", dname(which), lat, seen, exp_lat);
    end
  endtask

  task automatic test_directed();
    logic [15:0] da[6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h5A5A};
    logic [15:0] db[6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    logic        dc[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ds[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        acc;
    for (int i = 0; i < 6; i++)
      cycle(0, 1'b1, {48'd0, da[i]}, {48'd0, db[i]}, dc[i], ds[i], 1'b1, acc);
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra[20];
    logic [15:0] rb[20];
    logic        rc[20];
    logic        rs[20];
    logic [65:0] held = '0;
    logic        acc, ordy;
    int          idx = 0;
    int          cyc = 0;
    for (int i = 0; i < 20; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    popped[0] = 0;
    while (idx < 20 && cyc < 200) begin
      ordy = !(cyc >= 8 && cyc < 12);
      cycle(0, 1'b1, {48'd0, ra[idx]}, {48'd0, rb[idx]}, rc[idx], rs[idx], ordy, acc);
      if (acc) idx++;
      if (!ordy) begin
        tests_run++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, expected 0/1", obs_ready, obs_valid);
        end
        if (cyc == 8) held = {obs_sum, obs_cout, obs_ovf};
        else begin
          tests_run++;
          if ({obs_sum, obs_cout, obs_ovf} !== held) begin
            tests_failed++;
            $display("FAIL stall_hold: got %h, expected held %h", {obs_sum, obs_cout, obs_ovf}, held);
          end
        end
      end
      cyc++;
    end
    drain(0);
    tests_run++;
    if (idx != 20 || popped[0] != 20) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d sent %0d received, expected 20 and 20", idx, popped[0]);
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    bit   seen = 1'b0;
    for (int i = 0; i < 8; i++)
      cycle(0, 1'b1, 64'($urandom), 64'($urandom), 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    iv16 = 1'b0;
    rst  = 1'b1;
    #1;
    sample(0);
    tests_run++;
    if (obs_valid !== 1'b0 || obs_sum !== 64'd0 || obs_cout !== 1'b0 || obs_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: got valid=%b sum=%h cout=%b ovf=%b, expected all 0",
               obs_valid, obs_sum, obs_cout, obs_ovf);
    end
    q16.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    sample(0);
    tests_run++;
    if (obs_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_ready: got in_ready=%b, expected 1", obs_ready);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      if (obs_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL mid_reset_discard: got out_valid after reset, expected none");
    end
    test_latency(0, 6, 64'h0000_0000_0000_ABCD, 64'h0000_0000_0000_1111);
    drain(0);
  endtask

  task automatic test_sweep8();
    logic acc;
    int   rej = 0;
    test_latency(1, 2, 64'h0F, 64'h01);
    drain(1);
    for (int m = 0; m < 4; m++)
      for (int ai = 0; ai < 256; ai++)
        for (int j = 0; j < 16; j++) begin
          cycle(1, 1'b1, 64'(ai), 64'(j * 17), 1'(m & 1), 1'(m >> 1), 1'b1, acc);
          if (!acc) rej++;
        end
    drain(1);
    tests_run++;
    if (rej != 0) begin
      tests_failed++;
      $display("FAIL w8 sweep_accept: got %0d rejected beats, expected 0", rej);
    end
  endtask

  task automatic test_wide64();
    logic acc;
    test_latency(2, 8, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    drain(2);
    cycle(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, acc);
    cycle(2, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, acc);
    cycle(2, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 30; i++)
      cycle(2, 1'b1, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
            1'($urandom), 1'($urandom), 1'b1, acc);
    drain(2);
  endtask

  initial begin
    for (int w = 0; w < 3; w++) begin
      popped[w] = 0;
      drive(w, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_latency(0, 6, 64'h1234, 64'h0FFF);
    drain(0);
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_sweep8();
    test_wide64();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
